// File: rtl/bat_pkg.sv
// Shared BatAmateur definitions: program-loader state encoding and RAM port constants.
package bat_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    QUIESCE   = 3'd1,
    WAIT_WORD = 3'd2,
    WRITE     = 3'd3,
    RELEASE   = 3'd4
  } loader_state_e;

  localparam logic RAM_RW_WRITE = 1'b1;
  localparam int   DATA_W       = 16;

endpackage

// File: rtl/bat_program_loader.sv
// Halts the CPU, streams LENGTH words into RAM from BASE_ADDR, then pulses CPU reset.
// Outputs are registered from the next state; WORD_READY is additionally gated by ABORT.
module bat_program_loader #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DATA_W        = bat_pkg::DATA_W,
  parameter int ADDR_W        = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [15:0]       LENGTH,
  input  logic              WORD_VALID,
  input  logic [DATA_W-1:0] WORD_DATA,
  output logic              WORD_READY,
  output logic              HALT,
  output logic              CPU_RST,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] BUS_OUT,
  output logic              BUS_OE,
  output logic              EXT_RAM_EN,
  output logic              EXT_RAM_RW,
  output logic              BUSY,
  output logic              DONE,
  output logic              ABORTED
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  bat_pkg::loader_state_e state_q, state_d;
  logic [3:0]        settle_q, settle_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic              aborted_q, aborted_d;
  logic              ready_q, halt_q, cpu_rst_q, busy_q, done_q;
  logic              oe_q, en_q, rw_q;
  logic [ADDR_W-1:0] address_q;
  logic              xfer;

  assign xfer = (state_q == bat_pkg::WAIT_WORD) && WORD_VALID && !ABORT;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    count_d   = count_q;
    addr_d    = addr_q;
    bus_out_d = bus_out_q;
    aborted_d = aborted_q;
    if (state_q != bat_pkg::IDLE && ABORT) begin
      aborted_d = 1'b1;
    end
    case (state_q)
      bat_pkg::IDLE: begin
        if (START) begin
          addr_d    = BASE_ADDR;
          count_d   = LENGTH;
          settle_d  = 4'd0;
          aborted_d = 1'b0;
          state_d   = bat_pkg::QUIESCE;
        end
      end
      bat_pkg::QUIESCE: begin
        if (ABORT) begin
          state_d = bat_pkg::RELEASE;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = (count_q == 16'd0) ? bat_pkg::RELEASE : bat_pkg::WAIT_WORD;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      bat_pkg::WAIT_WORD: begin
        if (ABORT) begin
          state_d = bat_pkg::RELEASE;
        end else if (xfer) begin
          bus_out_d = WORD_DATA;
          state_d   = bat_pkg::WRITE;
        end
      end
      bat_pkg::WRITE: begin
        // The write in flight always completes; ABORT only shortens what follows.
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q - 16'd1;
        state_d = (ABORT || count_q == 16'd1) ? bat_pkg::RELEASE : bat_pkg::WAIT_WORD;
      end
      bat_pkg::RELEASE: state_d = bat_pkg::IDLE;
      default:          state_d = bat_pkg::IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= bat_pkg::IDLE;
      settle_q  <= 4'd0;
      count_q   <= 16'd0;
      addr_q    <= '0;
      bus_out_q <= '0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b0;
      halt_q    <= 1'b0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      oe_q      <= 1'b0;
      en_q      <= 1'b0;
      rw_q      <= 1'b0;
      address_q <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      aborted_q <= aborted_d;
      bus_out_q <= (state_d == bat_pkg::WRITE) ? bus_out_d : '0;
      ready_q   <= (state_d == bat_pkg::WAIT_WORD);
      halt_q    <= (state_d != bat_pkg::IDLE);
      busy_q    <= (state_d != bat_pkg::IDLE);
      cpu_rst_q <= (state_d == bat_pkg::RELEASE);
      done_q    <= (state_q == bat_pkg::RELEASE);
      oe_q      <= (state_d == bat_pkg::WRITE);
      en_q      <= (state_d == bat_pkg::WRITE);
      rw_q      <= (state_d == bat_pkg::WRITE) & bat_pkg::RAM_RW_WRITE;
      address_q <= (state_d == bat_pkg::WRITE) ? addr_q : '0;
    end
  end

  assign WORD_READY = ready_q & ~ABORT;
  assign HALT       = halt_q;
  assign CPU_RST    = cpu_rst_q;
  assign ADDRESS    = address_q;
  assign BUS_OUT    = bus_out_q;
  assign BUS_OE     = oe_q;
  assign EXT_RAM_EN = en_q;
  assign EXT_RAM_RW = rw_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ABORTED    = aborted_q;

endmodule

// File: tb/tb_bat_program_loader.sv
// Directed bench for bat_program_loader: RAM write log, reset/halt monitors, hand-computed timings.
module tb_bat_program_loader;

  localparam int S = 2;

  logic        CLK = 1'b0;
  logic        RST, START, ABORT, WORD_VALID;
  logic [15:0] BASE_ADDR, LENGTH, WORD_DATA;
  logic        WORD_READY, HALT, CPU_RST, BUS_OE, EXT_RAM_EN, EXT_RAM_RW, BUSY, DONE, ABORTED;
  logic [15:0] ADDRESS, BUS_OUT;

  bat_program_loader #(.SETTLE_CYCLES(S), .DATA_W(16), .ADDR_W(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .BASE_ADDR(BASE_ADDR), .LENGTH(LENGTH),
    .WORD_VALID(WORD_VALID), .WORD_DATA(WORD_DATA), .WORD_READY(WORD_READY),
    .HALT(HALT), .CPU_RST(CPU_RST), .ADDRESS(ADDRESS), .BUS_OUT(BUS_OUT),
    .BUS_OE(BUS_OE), .EXT_RAM_EN(EXT_RAM_EN), .EXT_RAM_RW(EXT_RAM_RW),
    .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model and protocol monitors, sampled at the edge that ends each cycle.
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int cpu_rst_cnt, halt_viol, halt_drop, en_cnt;

  always @(posedge CLK) begin
    if (EXT_RAM_EN && EXT_RAM_RW) begin
      wr_addr.push_back(ADDRESS);
      wr_data.push_back(BUS_OUT);
    end
    if (EXT_RAM_EN) en_cnt++;
    if (CPU_RST) cpu_rst_cnt++;
    if ((BUS_OE || EXT_RAM_EN) && !HALT) halt_viol++;
    if (BUSY && !HALT) halt_drop++;
  end

  logic [15:0] stim_q[$];

  function automatic logic [40:0] outs();
    return {WORD_READY, HALT, CPU_RST, BUSY, DONE, ABORTED, BUS_OE, EXT_RAM_EN, EXT_RAM_RW,
            ADDRESS, BUS_OUT};
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    cpu_rst_cnt = 0;
    halt_viol   = 0;
    halt_drop   = 0;
    en_cnt      = 0;
  endtask

  // Returns at the falling edge just after the START edge (cycle index 0).
  task automatic start_load(input logic [15:0] base, input logic [15:0] len);
    BASE_ADDR = base;
    LENGTH    = len;
    START     = 1'b1;
    @(negedge CLK);
    START     = 1'b0;
  endtask

  // Streams stim_q until DONE; optional ABORT on word abort_idx and a gap after word gap_idx.
  task automatic run_stream(input int abort_idx, input int gap_idx, input int gap_len,
                            output int cycles);
    int k = 0;
    int idx = 0;
    int gapleft = 0;
    while (DONE !== 1'b1 && k < 200) begin
      ABORT = 1'b0;
      if (gapleft > 0) begin
        WORD_VALID = 1'b0;
        gapleft--;
      end else if (idx < stim_q.size()) begin
        WORD_VALID = 1'b1;
        WORD_DATA  = stim_q[idx];
      end else begin
        WORD_VALID = 1'b0;
      end
      #1;
      if (WORD_READY && idx == abort_idx) ABORT = 1'b1;
      #1;
      if (WORD_VALID && WORD_READY) begin
        idx++;
        if (idx == gap_idx) gapleft = gap_len;
      end
      @(negedge CLK);
      k++;
    end
    WORD_VALID = 1'b0;
    ABORT      = 1'b0;
    cycles     = k;
  endtask

  initial begin
    int cyc;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; BASE_ADDR = '0; LENGTH = '0;
    WORD_VALID = 1'b0; WORD_DATA = '0;
    clear_log();
    repeat (3) @(negedge CLK);
    expect_eq("reset_outs", outs(), 41'd0);
    RST = 1'b0;
    @(negedge CLK);
    expect_eq("idle_outs", outs(), 41'd0);

    // Three gapless words from 0x0010: DONE at S+2*3+1.
    clear_log();
    stim_q = '{16'hA001, 16'hA002, 16'hA003};
    start_load(16'h0010, 16'd3);
    expect_eq("t1_halt_after_start", HALT, 1'b1);
    run_stream(-1, -1, 0, cyc);
    expect_eq("t1_cycles", cyc, S + 7);
    expect_eq("t1_halt_in_done", HALT, 1'b0);
    expect_eq("t1_wr_cnt", wr_addr.size(), 3);
    expect_eq("t1_wr0", {wr_addr[0], wr_data[0]}, {16'h0010, 16'hA001});
    expect_eq("t1_wr1", {wr_addr[1], wr_data[1]}, {16'h0011, 16'hA002});
    expect_eq("t1_wr2", {wr_addr[2], wr_data[2]}, {16'h0012, 16'hA003});
    expect_eq("t1_cpu_rst", cpu_rst_cnt, 1);
    expect_eq("t1_excl", halt_viol, 0);
    expect_eq("t1_aborted", ABORTED, 1'b0);
    @(negedge CLK);
    expect_eq("t1_done_pulse", {DONE, BUSY, HALT}, 3'b000);

    // LENGTH=0: straight from QUIESCE to RELEASE.
    clear_log();
    stim_q = '{};
    start_load(16'h0020, 16'd0);
    run_stream(-1, -1, 0, cyc);
    expect_eq("t2_cycles", cyc, S + 1);
    expect_eq("t2_no_en", en_cnt, 0);
    expect_eq("t2_cpu_rst", cpu_rst_cnt, 1);

    // Address wrap 0xFFFF -> 0x0000.
    clear_log();
    stim_q = '{16'hB001, 16'hB002};
    start_load(16'hFFFF, 16'd2);
    run_stream(-1, -1, 0, cyc);
    expect_eq("t3_cycles", cyc, S + 5);
    expect_eq("t3_wr_cnt", wr_addr.size(), 2);
    expect_eq("t3_wr0", {wr_addr[0], wr_data[0]}, {16'hFFFF, 16'hB001});
    expect_eq("t3_wr1", {wr_addr[1], wr_data[1]}, {16'h0000, 16'hB002});

    // Valid dropped for 5 cycles after word 0; the first idle cycle overlaps WRITE, so +4.
    clear_log();
    stim_q = '{16'hC001, 16'hC002, 16'hC003};
    start_load(16'h0100, 16'd3);
    run_stream(-1, 1, 5, cyc);
    expect_eq("t4_cycles", cyc, S + 7 + 4);
    expect_eq("t4_halt_held", halt_drop, 0);
    expect_eq("t4_wr_cnt", wr_addr.size(), 3);
    expect_eq("t4_wr1", {wr_addr[1], wr_data[1]}, {16'h0101, 16'hC002});
    expect_eq("t4_wr2", {wr_addr[2], wr_data[2]}, {16'h0102, 16'hC003});

    // ABORT coincides with the handshake of word 1: only word 0 lands.
    clear_log();
    stim_q = '{16'hD001, 16'hD002, 16'hD003};
    start_load(16'h0200, 16'd3);
    run_stream(1, -1, 0, cyc);
    expect_eq("t5_cycles", cyc, S + 4);
    expect_eq("t5_wr_cnt", wr_addr.size(), 1);
    expect_eq("t5_wr0", {wr_addr[0], wr_data[0]}, {16'h0200, 16'hD001});
    expect_eq("t5_aborted", ABORTED, 1'b1);
    expect_eq("t5_cpu_rst", cpu_rst_cnt, 1);
    @(negedge CLK);
    expect_eq("t5_aborted_sticky", ABORTED, 1'b1);
    clear_log();
    stim_q = '{};
    start_load(16'h0000, 16'd0);
    expect_eq("t5_start_clears", ABORTED, 1'b0);
    run_stream(-1, -1, 0, cyc);
    expect_eq("t5_restart_cycles", cyc, S + 1);

    // Reset asserted in the middle of a WRITE cycle.
    clear_log();
    start_load(16'h0300, 16'd2);
    WORD_VALID = 1'b1;
    WORD_DATA  = 16'hE001;
    cyc = 0;
    while (EXT_RAM_EN !== 1'b1 && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    expect_eq("t6_reached_write", EXT_RAM_EN, 1'b1);
    #2 RST = 1'b1;
    #1 expect_eq("t6_async_outs", outs(), 41'd0);
    WORD_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    expect_eq("t6_quiet_after_rst", {wr_addr.size() == 0, cpu_rst_cnt == 0, BUSY, DONE}, 4'b1100);
    clear_log();
    stim_q = '{16'hF001, 16'hF002};
    start_load(16'h0040, 16'd2);
    run_stream(-1, -1, 0, cyc);
    expect_eq("t6_clean_cycles", cyc, S + 5);
    expect_eq("t6_clean_wr0", {wr_addr[0], wr_data[0]}, {16'h0040, 16'hF001});
    expect_eq("t6_clean_wr1", {wr_addr[1], wr_data[1]}, {16'h0041, 16'hF002});
    expect_eq("t6_clean_cpu_rst", cpu_rst_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bat_program_loader.md
# bat_program_loader

Bus-master sequencer that loads a program image into the BatAmateur RAM while the CPU is held. On START it asserts HALT, waits for the in-flight micro-operation to settle, then writes LENGTH words from a valid/ready word stream to consecutive RAM addresses. It does this by driving the external RAM port, the ADDRESS lines and the shared BUS. At the end it pulses a CPU reset and releases HALT, so the CPU restarts at PC 0 on the new image. It sits at top level next to the CPU core and feeds its HALT, EXT_RAM_RW, EXT_RAM_EN and ADDRESS inputs. The BUS tristate buffer is instantiated at top level.

## Interface
- SETTLE_CYCLES, 2: cycles HALT is held before the first bus drive; legal range 1..15.
- DATA_W, 16: word and BUS width.
- ADDR_W, 16: address width.

- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request; sampled only in IDLE.
- ABORT  in  1  terminates a load in progress; sampled in every non-IDLE state.
- BASE_ADDR  in  ADDR_W  first RAM address; latched on an accepted START.
- LENGTH  in  16  number of words to write; latched on an accepted START; 0 is legal.
- WORD_VALID  in  1  stream word available.
- WORD_DATA  in  DATA_W  stream word.
- WORD_READY  out  1  loader accepts a word; a transfer occurs when WORD_VALID and WORD_READY are both high at an edge.
- HALT  out  1  freezes the CPU controller and hands the RAM port to this block.
- CPU_RST  out  1  reset pulse to the CPU core.
- ADDRESS  out  ADDR_W  RAM address; meaningful only while BUS_OE is high.
- BUS_OUT  out  DATA_W  data driven onto BUS.
- BUS_OE  out  1  enable for the top-level BUS tristate.
- EXT_RAM_EN  out  1  RAM enable.
- EXT_RAM_RW  out  1  RAM direction; 1 = write.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the block returns to IDLE.
- ABORTED  out  1  sticky flag; set by ABORT, cleared by the next accepted START.

## Operation
- All outputs are registered. Reset value of every output is 0. Internal address and count registers reset to 0 and the FSM resets to IDLE.
- IDLE
  - START=1 latches BASE_ADDR and LENGTH, clears ABORTED and moves to QUIESCE.
  - START is ignored in every other state.
- QUIESCE
  - HALT=1.
  - Stays exactly SETTLE_CYCLES cycles, then goes to WAIT_WORD, or to RELEASE if the remaining count is 0.
- WAIT_WORD
  - WORD_READY=1.
  - On a transfer, captures WORD_DATA and moves to WRITE.
- WRITE (one cycle)
  - BUS_OE=1, EXT_RAM_EN=1, EXT_RAM_RW=1, ADDRESS = current address, BUS_OUT = captured word.
  - On exit: address += 1, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000); remaining count -= 1.
  - Goes to WAIT_WORD if the remaining count is nonzero, otherwise to RELEASE.
- RELEASE (one cycle)
  - HALT=1, CPU_RST=1; bus outputs are all 0.
  - Next state is IDLE. DONE=1 in the first IDLE cycle and HALT drops in that same cycle.
- ABORT
  - In QUIESCE or WAIT_WORD, ABORT forces the next state to RELEASE and sets ABORTED. CPU_RST is still pulsed.
  - In WRITE, the current write completes first, then the block goes to RELEASE.
  - ABORT together with a transfer in WAIT_WORD: ABORT wins and the word is not accepted; WORD_READY is driven 0 combinationally from ABORT for that purpose.
- Bus exclusivity
  - BUS_OE and EXT_RAM_EN are 1 only in WRITE.
  - HALT is 1 in every cycle where BUS_OE is 1, and in the cycles before and after it.
- RST asserted mid-load: every output returns to 0 immediately (asynchronously), including HALT, and no DONE is produced.

## Timing
- START accepted at edge 0 → HALT=1 after edge 0.
- First WORD_READY=1 after edge SETTLE_CYCLES.
- Each word costs at least 2 cycles: one in WAIT_WORD, one in WRITE. RAM captures on the rising edge that ends WRITE.
- Best-case total for N ≥ 1 words: SETTLE_CYCLES + 2N + 1 cycles from the START edge to DONE.
- LENGTH=0: SETTLE_CYCLES + 1 cycles to DONE, with no RAM enable.
- WORD_VALID held low stalls the loader in WAIT_WORD indefinitely, with HALT held high.

## Structure
- Shared package bat_pkg:
  - loader state enum: IDLE, QUIESCE, WAIT_WORD, WRITE, RELEASE;
  - constant RAM_RW_WRITE = 1;
  - constant DATA_W = 16.
- No sub-module. The settle counter, word counter and address register are written inline; the whole block is one FSM with registered outputs.

## Test plan
- BASE_ADDR=0x0010, LENGTH=3, words 0xA001/0xA002/0xA003 streamed with no gaps → RAM writes to 0x10, 0x11, 0x12 with those values; DONE exactly SETTLE_CYCLES+7 cycles after START; one CPU_RST pulse; HALT drops in the DONE cycle.
- LENGTH=0 → no EXT_RAM_EN at any point; DONE SETTLE_CYCLES+1 cycles after START; CPU_RST pulsed once.
- BASE_ADDR=0xFFFF, LENGTH=2 → writes land at 0xFFFF then 0x0000.
- WORD_VALID dropped for 5 cycles between words → HALT stays high, no spurious write, and the word count still completes.
- ABORT in the same cycle as a WAIT_WORD transfer → that word is not written; ABORTED=1; DONE and CPU_RST still occur. A new START clears ABORTED.
- RST pulsed during WRITE → every output is 0 on the same cycle; a subsequent START runs a clean load.
